mult_rr_sched: RTL

- Round-robin scheduler that shares one digit-serial large-integer multiplier core between NREQ requesters.
- Per job, it:
  - arbitrates among pending requests;
  - latches the winner's operands;
  - pulses the core's local reset, then drives start until the core reports done;
  - returns the tagged product over a valid/ready result port.
- Sits between client engines and a single multiplier instance, so a multiplier core does not have to be replicated per client.

---
 rtl/mult_rr_sched.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one digit-serial multiplier core among NREQ requesters.
// Optional watchdog abort enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_rr_sched #(
  parameter int unsigned SIZEA          = 1024,
  parameter int unsigned SIZEB          = 1024,
  parameter int unsigned NREQ           = 4,
  parameter int unsigned IDW            = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*SIZEA-1:0]    req_a,
  input  logic [NREQ*SIZEB-1:0]    req_b,
  output logic [NREQ-1:0]          gnt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDW-1:0]           res_id,
  output logic [SIZEA+SIZEB-1:0]   res_c,
  output logic                     res_err,
  output logic                     core_rst,
  output logic                     core_start,
  output logic [SIZEA-1:0]         core_a,
  output logic [SIZEB-1:0]         core_b,
  input  logic [SIZEA+SIZEB-1:0]   core_c,
  input  logic                     core_done
);

  localparam int unsigned CW = SIZEA + SIZEB;
  localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 16 || IDW < SW || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mult_rr_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CLR, RUN, REL} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   r_cur_id, w_cur_id_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic [IDW-1:0]   r_res_id, w_res_id_nxt;
  logic [CW-1:0]    r_res_c, w_res_c_nxt;
  logic             r_core_rst, w_core_rst_nxt;
  logic             r_core_start, w_core_start_nxt;
  logic [SIZEA-1:0] r_core_a, w_core_a_nxt;
  logic [SIZEB-1:0] r_core_b, w_core_b_nxt;
  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic             w_slot_free;
  int unsigned      w_idx;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          r_res_err, w_res_err_nxt;
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
`endif

  // Rotating priority: first pending request at or above ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req[SW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = IDW'(w_idx);
      end
    end
  end

  assign w_slot_free = !r_res_valid || res_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cur_id_nxt     = r_cur_id;
    w_gnt_nxt        = '0;
    w_res_valid_nxt  = r_res_valid;
    w_res_id_nxt     = r_res_id;
    w_res_c_nxt      = r_res_c;
    w_core_rst_nxt   = 1'b0;
    w_core_start_nxt = r_core_start;
    w_core_a_nxt     = r_core_a;
    w_core_b_nxt     = r_core_b;
`ifdef MULT_SCHED_TIMEOUT_EN
    w_res_err_nxt    = r_res_err;
    w_tmo_cnt_nxt    = r_tmo_cnt;
`endif
    if (r_res_valid && res_ready) begin
      w_res_valid_nxt = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
      w_res_err_nxt   = 1'b0;
`endif
    end
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_nxt      = NREQ'(1) << w_sel;
          w_core_a_nxt   = req_a[32'(w_sel)*SIZEA +: SIZEA];
          w_core_b_nxt   = req_b[32'(w_sel)*SIZEB +: SIZEB];
          w_cur_id_nxt   = w_sel;
          w_core_rst_nxt = 1'b1;
          w_state_nxt    = CLR;
        end
      end
      CLR: begin
        w_core_start_nxt = 1'b1;
        w_state_nxt      = RUN;
`ifdef MULT_SCHED_TIMEOUT_EN
        w_tmo_cnt_nxt    = '0;
`endif
      end
      RUN: begin
        if (core_done && w_slot_free) begin
          w_res_c_nxt      = core_c;
          w_res_id_nxt     = r_cur_id;
          w_res_valid_nxt  = 1'b1;
          w_core_start_nxt = 1'b0;
          w_core_rst_nxt   = 1'b1;
          w_state_nxt      = REL;
`ifdef MULT_SCHED_TIMEOUT_EN
          w_res_err_nxt    = 1'b0;
        end else if (!core_done && w_slot_free && r_tmo_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog abort: report a zero product flagged as an error.
          w_res_c_nxt      = '0;
          w_res_id_nxt     = r_cur_id;
          w_res_valid_nxt  = 1'b1;
          w_res_err_nxt    = 1'b1;
          w_core_start_nxt = 1'b0;
          w_core_rst_nxt   = 1'b1;
          w_state_nxt      = REL;
        end else if (r_tmo_cnt < TW'(TIMEOUT_CYCLES)) begin
          w_tmo_cnt_nxt    = r_tmo_cnt + TW'(1);
`endif
        end
      end
      REL: begin
        w_ptr_nxt   = (r_cur_id == IDW'(NREQ - 1)) ? '0 : r_cur_id + IDW'(1);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_cur_id     <= '0;
      r_gnt        <= '0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_c      <= '0;
      r_core_rst   <= 1'b0;
      r_core_start <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      r_res_err    <= 1'b0;
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cur_id     <= w_cur_id_nxt;
      r_gnt        <= w_gnt_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_res_id     <= w_res_id_nxt;
      r_res_c      <= w_res_c_nxt;
      r_core_rst   <= w_core_rst_nxt;
      r_core_start <= w_core_start_nxt;
      r_core_a     <= w_core_a_nxt;
      r_core_b     <= w_core_b_nxt;
`ifdef MULT_SCHED_TIMEOUT_EN
      r_res_err    <= w_res_err_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign gnt        = r_gnt;
  assign res_valid  = r_res_valid;
  assign res_id     = r_res_id;
  assign res_c      = r_res_c;
  assign core_rst   = r_core_rst;
  assign core_start = r_core_start;
  assign core_a     = r_core_a;
  assign core_b     = r_core_b;
`ifdef MULT_SCHED_TIMEOUT_EN
  assign res_err    = r_res_err;
`else
  assign res_err    = 1'b0;
`endif

endmodule
